// File: rtl/channel_scanner.sv
// rtl/channel_scanner.sv - sequences a 4-bit channel index through the enabled bits of a 16-bit mask
// Optional feature macro SCAN_HOLD_EN adds i_hold, which freezes the dwell counter while scanning.
module channel_scanner #(
  parameter int DWELL_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_continuous,
  input  logic [15:0]        i_mask,
  input  logic [DWELL_W-1:0] i_dwell,
`ifdef SCAN_HOLD_EN
  input  logic               i_hold,
`endif
  output logic [3:0]         o_ch_idx,
  output logic               o_ch_valid,
  output logic               o_ch_first,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err_empty
);

  typedef enum logic [0:0] {IDLE, SCAN} state_t;

  state_t             r_state;
  logic [15:0]        r_mask_q;
  logic               r_cont_q;
  logic [DWELL_W-1:0] r_cnt;
  logic [3:0]         r_ch_idx;
  logic               r_ch_first;
  logic               r_done;
  logic               r_err_empty;

  state_t             w_state;
  logic [15:0]        w_mask_q;
  logic               w_cont_q;
  logic [DWELL_W-1:0] w_cnt;
  logic [3:0]         w_ch_idx;
  logic               w_ch_first;
  logic               w_done;
  logic               w_err_empty;

  logic               w_hold;
  logic [3:0]         w_low_idx;
  logic [3:0]         w_next_idx;
  logic               w_next_found;

`ifdef SCAN_HOLD_EN
  assign w_hold = i_hold;
`else
  assign w_hold = 1'b0;
`endif

  // Lowest set bit of the live mask, used on start and on wrap.
  always_comb begin
    w_low_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (i_mask[i]) w_low_idx = 4'(i);
    end
  end

  // Lowest set bit of the latched mask strictly above the current channel.
  always_comb begin
    w_next_idx   = 4'd0;
    w_next_found = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (r_mask_q[i] && (i > int'(r_ch_idx))) begin
        w_next_idx   = 4'(i);
        w_next_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state     = r_state;
    w_mask_q    = r_mask_q;
    w_cont_q    = r_cont_q;
    w_cnt       = r_cnt;
    w_ch_idx    = r_ch_idx;
    w_ch_first  = 1'b0;
    w_done      = 1'b0;
    w_err_empty = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !i_stop) begin
          if (i_mask != 16'd0) begin
            w_mask_q   = i_mask;
            w_cont_q   = i_continuous;
            w_ch_idx   = w_low_idx;
            w_cnt      = i_dwell;
            w_ch_first = 1'b1;
            w_state    = SCAN;
          end else begin
            w_err_empty = 1'b1;
          end
        end
      end
      SCAN: begin
        if (i_stop) begin
          w_state = IDLE;
          w_done  = 1'b1;
        end else if (w_hold) begin
          w_cnt = r_cnt;
        end else if (r_cnt != '0) begin
          w_cnt = r_cnt - 1'b1;
        end else if (w_next_found) begin
          w_ch_idx   = w_next_idx;
          w_cnt      = i_dwell;
          w_ch_first = 1'b1;
        end else if (!r_cont_q) begin
          w_state = IDLE;
          w_done  = 1'b1;
        end else begin
          // Wrap: the live mask is re-sampled only here, so mid-sweep edits wait for it.
          w_mask_q = i_mask;
          if (i_mask != 16'd0) begin
            w_ch_idx   = w_low_idx;
            w_cnt      = i_dwell;
            w_ch_first = 1'b1;
          end else begin
            w_state     = IDLE;
            w_done      = 1'b1;
            w_err_empty = 1'b1;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_mask_q    <= 16'd0;
      r_cont_q    <= 1'b0;
      r_cnt       <= '0;
      r_ch_idx    <= 4'd0;
      r_ch_first  <= 1'b0;
      r_done      <= 1'b0;
      r_err_empty <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_mask_q    <= w_mask_q;
      r_cont_q    <= w_cont_q;
      r_cnt       <= w_cnt;
      r_ch_idx    <= w_ch_idx;
      r_ch_first  <= w_ch_first;
      r_done      <= w_done;
      r_err_empty <= w_err_empty;
    end
  end

  assign o_ch_idx    = r_ch_idx;
  assign o_ch_valid  = (r_state == SCAN);
  assign o_busy      = (r_state == SCAN);
  assign o_ch_first  = r_ch_first;
  assign o_done      = r_done;
  assign o_err_empty = r_err_empty;

endmodule

// File: tb/tb_channel_scanner.sv
// tb/tb_channel_scanner.sv - scoreboard bench for channel_scanner with a sweep-list reference model
module tb_channel_scanner;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic          continuous;
  logic [15:0]   mask;
  logic [DW-1:0] dwell;
`ifdef SCAN_HOLD_EN
  logic          hold;
`endif
  logic [3:0]    o_ch_idx;
  logic          o_ch_valid;
  logic          o_ch_first;
  logic          o_busy;
  logic          o_done;
  logic          o_err_empty;

  channel_scanner #(.DWELL_W(DW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_stop       (stop),
    .i_continuous (continuous),
    .i_mask       (mask),
    .i_dwell      (dwell),
`ifdef SCAN_HOLD_EN
    .i_hold       (hold),
`endif
    .o_ch_idx     (o_ch_idx),
    .o_ch_valid   (o_ch_valid),
    .o_ch_first   (o_ch_first),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err_empty  (o_err_empty)
  );

  always #5 clk = ~clk;

  localparam int EV_VALID = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ERR   = 2;

  typedef struct {
    int kind;
    int idx;
    bit first;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void push(input int kind, input int idx, input bit first);
    exp_t e;
    e.kind  = kind;
    e.idx   = idx;
    e.first = first;
    q.push_back(e);
  endfunction

  // Expected trace: sweep the set bits of m1 ascending, each for d+1 cycles; in continuous
  // mode every later sweep uses m2. A stop sampled after K valid cycles ends the run.
  task automatic model_run(input logic [15:0] m1, input logic [15:0] m2, input int d,
                           input bit cont, input int k, output int l);
    logic [15:0] m;
    int n;
    bit fin;
    m = m1;
    n = 0;
    fin = 1'b0;
    l = 0;
    if (m1 == 16'd0) begin
      push(EV_ERR, 0, 1'b0);
      return;
    end
    while (!fin) begin
      for (int ch = 0; ch < 16 && !fin; ch++) begin
        if (m[ch]) begin
          for (int c = 0; c <= d && !fin; c++) begin
            push(EV_VALID, ch, c == 0);
            n++;
            if (n == k) begin
              push(EV_DONE, 0, 1'b0);
              fin = 1'b1;
            end
          end
        end
      end
      if (!fin) begin
        if (!cont) begin
          push(EV_DONE, 0, 1'b0);
          fin = 1'b1;
        end else begin
          m = m2;
          if (m == 16'd0) begin
            push(EV_DONE, 0, 1'b0);
            push(EV_ERR, 0, 1'b0);
            fin = 1'b1;
          end
        end
      end
    end
    l = n;
  endtask

  task automatic expect_ev(input int kind);
    exp_t e;
    if (q.size() == 0) begin
      check(1'b0, "unexpected_output", kind, -1);
      return;
    end
    e = q.pop_front();
    check(e.kind == kind, "event_kind", kind, e.kind);
    if (kind == EV_VALID && e.kind == EV_VALID) begin
      check(int'(o_ch_idx) == e.idx, "ch_idx", int'(o_ch_idx), e.idx);
      check(o_ch_first == e.first, "ch_first", int'(o_ch_first), int'(e.first));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check(o_ch_valid == o_busy, "valid_eq_busy", int'(o_ch_valid), int'(o_busy));
      check(!(o_done && o_ch_first), "done_first_excl", int'(o_done && o_ch_first), 0);
      if (!o_ch_valid) check(!o_ch_first, "first_without_valid", int'(o_ch_first), 0);
      if (o_ch_valid)  expect_ev(EV_VALID);
      if (o_done)      expect_ev(EV_DONE);
      if (o_err_empty) expect_ev(EV_ERR);
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (o_busy && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(t < 3000, "idle_timeout", t, 3000);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // k<=0 means no stop; poke=1 throws start pulses at the DUT while it is busy.
  task automatic do_run(input logic [15:0] m1, input logic [15:0] m2, input int d,
                        input bit cont, input int k, input bit poke);
    int l;
    model_run(m1, m2, d, cont, k, l);
    @(posedge clk);
    #1;
    mask       = m1;
    dwell      = DW'(d);
    continuous = cont;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mask  = m2;
    if (k > 0) begin
      for (int j = 1; j < k; j++) begin
        start = (poke && j <= l) ? 1'($urandom % 2) : 1'b0;
        @(posedge clk);
        #1;
      end
      start = 1'b0;
      stop  = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
    end
    wait_idle();
    check(q.size() == 0, "queue_drained", q.size(), 0);
    q.delete();
  endtask

  function automatic logic [15:0] mkmask();
    case ($urandom % 4)
      0:       return 16'(1) << ($urandom % 16);
      1:       return 16'($urandom);
      2:       return 16'($urandom) & 16'($urandom);
      default: return ($urandom % 3 == 0) ? 16'h0000 : 16'($urandom);
    endcase
  endfunction

  initial begin
    int l;
    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    continuous = 1'b0;
    mask       = 16'h0000;
    dwell      = '0;
`ifdef SCAN_HOLD_EN
    hold       = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check(o_ch_idx == 4'd0, "rst_ch_idx", int'(o_ch_idx), 0);
    check(!o_ch_valid && !o_busy, "rst_valid_busy", int'({o_ch_valid, o_busy}), 0);
    check(!o_ch_first && !o_done && !o_err_empty, "rst_pulses",
          int'({o_ch_first, o_done, o_err_empty}), 0);
    mon_en = 1'b1;

    do_run(16'h0000, 16'h0000, 0, 1'b0, 0, 1'b0);
    do_run(16'h8421, 16'h0000, 0, 1'b0, 0, 1'b0);
    check(o_ch_idx == 4'd15, "idx_hold_after_done", int'(o_ch_idx), 15);
    do_run(16'h0009, 16'h0009, 2, 1'b1, 8, 1'b0);
    check(o_ch_idx == 4'd0, "idx_after_stop", int'(o_ch_idx), 0);
    do_run(16'h0100, 16'h0100, 1, 1'b1, 10, 1'b1);
    do_run(16'h0010, 16'h0000, 255, 1'b0, 0, 1'b0);
    do_run(16'h0003, 16'h0000, 0, 1'b1, 0, 1'b0);

    // start and stop together from idle: nothing may happen
    @(posedge clk);
    #1;
    mask  = 16'hFFFF;
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(!o_busy, "start_stop_idle", int'(o_busy), 0);

    // reset in the middle of a sweep drops all pending expectations
    model_run(16'hFFFF, 16'hFFFF, 3, 1'b0, 0, l);
    mask  = 16'hFFFF;
    dwell = DW'(3);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    check(!o_ch_valid && !o_busy, "midrst_valid_busy", int'({o_ch_valid, o_busy}), 0);
    check(!o_done && !o_ch_first && !o_err_empty, "midrst_pulses",
          int'({o_done, o_ch_first, o_err_empty}), 0);
    check(o_ch_idx == 4'd0, "midrst_ch_idx", int'(o_ch_idx), 0);
    do_run(16'hFFFF, 16'hFFFF, 0, 1'b0, 0, 1'b0);

`ifdef SCAN_HOLD_EN
    push(EV_VALID, 1, 1'b1);
    for (int i = 0; i < 5; i++) push(EV_VALID, 1, 1'b0);
    push(EV_VALID, 2, 1'b1);
    push(EV_DONE, 0, 1'b0);
    @(posedge clk);
    #1;
    mask       = 16'h0006;
    dwell      = '0;
    continuous = 1'b0;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    hold  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    hold = 1'b0;
    wait_idle();
    check(q.size() == 0, "hold_queue_drained", q.size(), 0);
    q.delete();
`endif

    for (int r = 0; r < 30; r++) begin
      logic [15:0] m1;
      logic [15:0] m2;
      bit          cont;
      int          d;
      int          k;
      m1   = mkmask();
      m2   = mkmask();
      cont = 1'($urandom % 2);
      if (cont) begin
        d = ($urandom % 8 == 0) ? 255 : int'($urandom % 4);
        k = int'($urandom_range(1, 60));
      end else begin
        d = int'($urandom % 4);
        k = ($urandom % 2 == 0) ? 0 : int'($urandom_range(1, 40));
      end
      do_run(m1, m2, d, cont, k, 1'($urandom % 2));
    end

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/channel_scanner.md
Name: channel_scanner

Overview:
- Upstream index generator for the 4-to-16 one-hot decoder stage.
- Sequences a 4-bit channel index through the enabled channels of a 16-bit mask, holding each channel for a programmable number of cycles.
- Runs as a single sweep or continuously.
- ch_idx drives the decoder's 4-bit select. ch_valid qualifies whether the decoded one-hot output should be used downstream.

Parameters:
DWELL_W, 8, width of dwell count; each channel is held for dwell+1 cycles

Ports:
clk  input  1  single clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begins a sweep when idle; ignored while busy
stop  input  1  aborts the sweep; priority over start and advance
continuous  input  1  sampled at start: 1 = wrap and repeat, 0 = single sweep
mask  input  16  per-channel enable, bit n = channel n
dwell  input  DWELL_W  hold count, latched each time a channel is entered
ch_idx  output  4  current channel index, feeds the decoder select
ch_valid  output  1  high while a channel is being driven
ch_first  output  1  one-cycle pulse on the first cycle of each channel visit
busy  output  1  high in SCAN state
done  output  1  one-cycle pulse on sweep completion or stop
err_empty  output  1  one-cycle pulse when the latched/sampled mask is zero

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state IDLE; ch_idx=0, ch_valid=0, ch_first=0, busy=0, done=0, err_empty=0; internal mask_q=0, cnt=0.
  - Reset mid-sweep aborts the sweep with no done pulse.
- States: IDLE, SCAN.
- IDLE, start=1, stop=0, mask!=0:
  - mask_q<=mask, cont_q<=continuous.
  - ch_idx<=lowest set bit of mask, cnt<=dwell.
  - Outputs ch_valid=1, ch_first=1, busy=1 from the next cycle; go to SCAN.
  - Latency: start at edge N gives the first channel valid at cycle N+1.
- IDLE, start=1, mask==0: err_empty pulses for 1 cycle; remain IDLE.
- IDLE, start=1 and stop=1 together: stop wins; remain IDLE; no pulses.
- SCAN, stop=1: next cycle IDLE, ch_valid=0, busy=0, done pulses for 1 cycle; ch_idx holds its last value.
- SCAN, cnt!=0: cnt decrements; ch_idx unchanged; ch_first=0.
- SCAN, cnt==0 (advance):
  - Next channel = lowest set bit of mask_q strictly above ch_idx (combinational priority search).
  - If found: ch_idx<=next, cnt<=dwell, ch_first pulses.
  - If none (end of sweep) and cont_q=0: go IDLE, ch_valid=0, busy=0, done pulses, ch_idx holds.
  - If none and cont_q=1:
    - Re-latch mask_q<=mask, then ch_idx<=lowest set bit of the new mask, cnt<=dwell, ch_first pulses.
    - If the new mask==0: go IDLE, done and err_empty pulse in the same cycle.
- Mask changes mid-sweep are ignored until the next wrap or the next start.
- dwell changes take effect at the next channel entry.
- Single enabled bit with cont_q=1: ch_idx constant; ch_first pulses every dwell+1 cycles.
- dwell=0 gives one cycle per channel. dwell=2^DWELL_W-1 gives 2^DWELL_W cycles per channel; the counter does not overflow.
- Invariant: ch_valid==busy.
- Invariant: done and ch_first are never high in the same cycle.
- Invariant: ch_idx always indexes a set bit of mask_q while ch_valid=1.

Optional Feature:
SCAN_HOLD_EN
- Defined: adds input port hold (1 bit). In SCAN with hold=1 and stop=0, cnt freezes and no advance occurs; ch_idx and ch_valid are held. stop still aborts during hold. hold is ignored in IDLE.
- Undefined: no hold port; the counter always runs.

Test Plan:
- mask=16'h0000, start pulse -> err_empty=1 for exactly 1 cycle; busy, ch_valid and done stay 0.
- mask=16'h8421, dwell=0, continuous=0, start -> ch_idx=0,5,10,15 on 4 consecutive cycles with ch_first=1 each; then done=1 for 1 cycle, ch_valid=0, ch_idx holds 15.
- mask=16'h0009, dwell=2, continuous=1, start -> ch_idx 0 for 3 cycles, 3 for 3 cycles, then 0 again (wrap); assert stop on the 8th valid cycle -> next cycle ch_valid=0, done=1, ch_idx=0.
- mask=16'h0100, dwell=1, continuous=1 -> ch_idx stays 8; ch_first pulses every 2nd cycle; start pulses while busy have no effect.
- Mid-sweep rst=1 for 1 cycle with mask=16'hFFFF, dwell=3 -> next cycle all outputs 0 and no done pulse; a subsequent start restarts at ch_idx=0.
- SCAN_HOLD_EN defined, mask=16'h0006, dwell=0: hold=1 for 5 cycles while at channel 1 -> ch_idx=1 for 6 cycles, then 2, then done.
